// File: rtl/memory_arbiter_pkg.sv
// Shared types for the memory arbiter: RAM handshake state, datapath word and FSM state.
package memory_arbiter_pkg;

    typedef logic [31:0] word_t;

    // RAM model status as seen by the arbiter.
    typedef enum logic [1:0] {
        FREE,
        BUSY,
        ACCESS,
        ERROR
    } ramstate_t;

    // Arbiter FSM: idle, data grant, instruction grant, sticky error.
    typedef enum logic [1:0] {
        IDLE,
        DACC,
        IACC,
        ERR
    } arb_state_t;

    // Width of the wait counter; TIMEOUT must fit in it.
    localparam int unsigned WAIT_W = 4;

    // A data request is either a read or a write.
    function automatic logic data_req(input logic ren, input logic wen);
        return ren | wen;
    endfunction

endpackage

// File: rtl/memory_arbiter_if.sv
// Bundle of datapath-side and RAM-side signals around the memory arbiter.
// master: the arbiter itself. slave: the environment (datapath plus RAM model).
interface memory_arbiter_if;
    import memory_arbiter_pkg::*;

    // Instruction-fetch requester
    logic      iREN;
    word_t     iaddr;
    word_t     iload;
    logic      ihit;

    // Data-access requester
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    word_t     dload;
    logic      dhit;

    // RAM port
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    // Sticky error
    logic      merr;

    modport master (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iload, ihit, dload, dhit, ramREN, ramWEN, ramaddr, ramstore, merr
    );

    modport slave (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iload, ihit, dload, dhit, ramREN, ramWEN, ramaddr, ramstore, merr
    );

endinterface

// File: rtl/memory_arbiter_access_timer.sv
// Wait counter for a granted RAM access: counts granted cycles without ACCESS and
// flags expiry on the TIMEOUT-th such cycle so the FSM can move to ERR that edge.
module memory_arbiter_access_timer
    import memory_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    logic [WAIT_W-1:0] cnt_q;
    logic [WAIT_W-1:0] cnt_d;

    // Next count: clear wins over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expires when this waiting cycle would bring the count up to TIMEOUT.
    assign expired_o = en_i && (cnt_q == WAIT_W'(TIMEOUT - 1));

endmodule

// File: rtl/memory_arbiter.sv
// Shares one RAM port between instruction fetch and data access. A registered FSM
// grants one requester at a time; hits and loads are combinational from the grant
// and the RAM status. Data wins ties unless it won the previous grant.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              CLK,
    input  logic              RST,
    memory_arbiter_if.master  arb_io
);

    arb_state_t state_q, state_d;
    logic       last_d_q, last_d_d;
    logic       merr_q, merr_d;

    logic       d_req;
    logic       granted;
    logic       req_live;
    logic       ram_access;
    logic       ram_error;
    logic       timer_en;
    logic       timer_exp;

    logic       ihit, dhit;
    logic       ram_ren, ram_wen;
    word_t      iload, dload, ram_addr, ram_store;

    assign d_req      = data_req(arb_io.dREN, arb_io.dWEN);
    assign ram_access = (arb_io.ramstate == ACCESS);
    assign ram_error  = (arb_io.ramstate == ERROR);
    assign granted    = (state_q == DACC) || (state_q == IACC);

    // Is the granted requester still asserting its request this cycle.
    always_comb begin
        req_live = 1'b0;
        unique case (state_q)
            DACC:    req_live = d_req;
            IACC:    req_live = arb_io.iREN;
            default: req_live = 1'b0;
        endcase
    end

    // Count only cycles where the grant is live and the RAM has not answered.
    assign timer_en = granted && req_live && !ram_access && !ram_error;

    memory_arbiter_access_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk_i     (CLK),
        .rst_i     (RST),
        .clr_i     (!granted),
        .en_i      (timer_en),
        .expired_o (timer_exp)
    );

    // RAM strobes, hits and loads from the current grant.
    always_comb begin
        ihit      = 1'b0;
        dhit      = 1'b0;
        iload     = '0;
        dload     = '0;
        ram_ren   = 1'b0;
        ram_wen   = 1'b0;
        ram_addr  = '0;
        ram_store = '0;
        unique case (state_q)
            DACC: begin
                if (d_req) begin
                    ram_wen   = arb_io.dWEN;
                    ram_ren   = arb_io.dREN & ~arb_io.dWEN;
                    ram_addr  = arb_io.daddr;
                    ram_store = arb_io.dstore;
                    if (ram_access) begin
                        dhit  = 1'b1;
                        dload = arb_io.ramload;
                    end
                end
            end
            IACC: begin
                if (arb_io.iREN) begin
                    ram_ren  = 1'b1;
                    ram_addr = arb_io.iaddr;
                    if (ram_access) begin
                        ihit  = 1'b1;
                        iload = arb_io.ramload;
                    end
                end
            end
            default: ;
        endcase
    end

    // Next-state, fairness and sticky-error logic.
    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        merr_d   = merr_q;
        unique case (state_q)
            IDLE: begin
                if (d_req && !(arb_io.iREN && last_d_q)) begin
                    state_d = DACC;
                end else if (arb_io.iREN) begin
                    state_d = IACC;
                end
            end
            DACC, IACC: begin
                // A dropped request abandons the grant even if RAM reports ACCESS.
                if (!req_live) begin
                    state_d = IDLE;
                end else if (ram_access) begin
                    state_d = IDLE;
                end else if (ram_error || timer_exp) begin
                    state_d = ERR;
                end
            end
            ERR:     state_d = ERR;
            default: state_d = IDLE;
        endcase
        if (dhit) begin
            last_d_d = 1'b1;
        end else if (ihit) begin
            last_d_d = 1'b0;
        end
        if (state_d == ERR) begin
            merr_d = 1'b1;
        end
    end

    // FSM state register with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
            merr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            merr_q   <= merr_d;
        end
    end

    assign arb_io.ihit     = ihit;
    assign arb_io.iload    = iload;
    assign arb_io.dhit     = dhit;
    assign arb_io.dload    = dload;
    assign arb_io.ramREN   = ram_ren;
    assign arb_io.ramWEN   = ram_wen;
    assign arb_io.ramaddr  = ram_addr;
    assign arb_io.ramstore = ram_store;
    assign arb_io.merr     = merr_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: per-cycle vector table plus a timeout sequence.
module tb_memory_arbiter;
    import memory_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    memory_arbiter_if bus ();

    memory_arbiter #(
        .TIMEOUT (15)
    ) dut (
        .CLK    (clk),
        .RST    (rst),
        .arb_io (bus)
    );

    typedef struct packed {
        logic  ihit;
        word_t iload;
        logic  dhit;
        word_t dload;
        logic  ren;
        logic  wen;
        word_t addr;
        word_t store;
        logic  merr;
    } outs_t;

    typedef struct {
        string     name;
        logic      rst;
        logic      iren;
        word_t     iaddr;
        logic      dren;
        logic      dwen;
        word_t     daddr;
        word_t     dstore;
        word_t     ramload;
        ramstate_t rs;
        outs_t     exp;
    } vec_t;

    localparam outs_t Z = '0;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic outs_t mk(logic ih, word_t il, logic dh, word_t dl, logic rn,
                                 logic wn, word_t ad, word_t st, logic me);
        outs_t o;
        o.ihit = ih; o.iload = il; o.dhit = dh; o.dload = dl;
        o.ren = rn; o.wen = wn; o.addr = ad; o.store = st; o.merr = me;
        return o;
    endfunction

    function automatic string fmt(outs_t o);
        return $sformatf("ihit=%b iload=%h dhit=%b dload=%h ren=%b wen=%b addr=%h store=%h merr=%b",
                         o.ihit, o.iload, o.dhit, o.dload, o.ren, o.wen, o.addr, o.store,
                         o.merr);
    endfunction

    function automatic outs_t sample();
        return mk(bus.ihit, bus.iload, bus.dhit, bus.dload, bus.ramREN, bus.ramWEN,
                  bus.ramaddr, bus.ramstore, bus.merr);
    endfunction

    task automatic add(string nm, logic r, logic ir, word_t ia, logic dr, logic dw,
                       word_t da, word_t ds, word_t rl, ramstate_t rs, outs_t e);
        vec_t v;
        v.name = nm; v.rst = r; v.iren = ir; v.iaddr = ia; v.dren = dr; v.dwen = dw;
        v.daddr = da; v.dstore = ds; v.ramload = rl; v.rs = rs; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic drive(logic r, logic ir, word_t ia, logic dr, logic dw, word_t da,
                         word_t ds, word_t rl, ramstate_t rs);
        rst = r; bus.iREN = ir; bus.iaddr = ia; bus.dREN = dr; bus.dWEN = dw;
        bus.daddr = da; bus.dstore = ds; bus.ramload = rl; bus.ramstate = rs;
    endtask

    task automatic check(string nm, outs_t got, outs_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got {%s} expected {%s}", nm, fmt(got), fmt(exp));
        end
    endtask

    task automatic check_int(string nm, int got, int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // One cycle: drive after the edge, sample at the falling edge.
    task automatic cycle(logic r, logic ir, word_t ia, logic dr, logic dw, word_t da,
                         word_t ds, word_t rl, ramstate_t rs);
        @(posedge clk);
        #1;
        drive(r, ir, ia, dr, dw, da, ds, rl, rs);
        @(negedge clk);
    endtask

    initial begin
        int ren_cycles;
        bit saw_err;
        bit saw_ihit;

        // Reset state
        add("reset", 1, 0, 0, 0, 0, 0, 0, 0, FREE, Z);
        // Instruction fetch with two BUSY cycles
        add("t1 req",   0, 1, 32'h4, 0, 0, 0, 0, 0, FREE, Z);
        add("t1 busy1", 0, 1, 32'h4, 0, 0, 0, 0, 0, BUSY, mk(0, 0, 0, 0, 1, 0, 32'h4, 0, 0));
        add("t1 busy2", 0, 1, 32'h4, 0, 0, 0, 0, 0, BUSY, mk(0, 0, 0, 0, 1, 0, 32'h4, 0, 0));
        add("t1 hit",   0, 1, 32'h4, 0, 0, 0, 0, 32'h3C010001, ACCESS,
            mk(1, 32'h3C010001, 0, 0, 1, 0, 32'h4, 0, 0));
        add("t1 idle",  0, 0, 0, 0, 0, 0, 0, 0, FREE, Z);
        // Data write wins the first tie, instruction follows two cycles later
        add("t2 req",  0, 1, 32'h8, 0, 1, 32'h100, 32'hDEADBEEF, 0, FREE, Z);
        add("t2 dhit", 0, 1, 32'h8, 0, 1, 32'h100, 32'hDEADBEEF, 32'h11111111, ACCESS,
            mk(0, 0, 1, 32'h11111111, 0, 1, 32'h100, 32'hDEADBEEF, 0));
        add("t2 gap",  0, 1, 32'h8, 0, 0, 0, 0, 32'h11111111, ACCESS, Z);
        add("t2 ihit", 0, 1, 32'h8, 0, 0, 0, 0, 32'h22222222, ACCESS,
            mk(1, 32'h22222222, 0, 0, 1, 0, 32'h8, 0, 0));
        add("t2 idle", 0, 0, 0, 0, 0, 0, 0, 0, FREE, Z);
        // Alternation with both requesters held: d, i, d, i
        for (int k = 0; k < 8; k++) begin
            outs_t e;
            unique case (k % 4)
                1:       e = mk(0, 0, 1, 32'h5A5A5A5A, 1, 0, 32'h200, 0, 0);
                3:       e = mk(1, 32'h5A5A5A5A, 0, 0, 1, 0, 32'hC, 0, 0);
                default: e = Z;
            endcase
            add($sformatf("t3 alt%0d", k), 0, 1, 32'hC, 1, 0, 32'h200, 0, 32'h5A5A5A5A,
                ACCESS, e);
        end
        add("t3 idle", 0, 0, 0, 0, 0, 0, 0, 0, FREE, Z);
        // Data request dropped mid-grant: no hit even with ACCESS
        add("drop req",  0, 0, 0, 1, 0, 32'h500, 0, 0, FREE, Z);
        add("drop busy", 0, 0, 0, 1, 0, 32'h500, 0, 0, BUSY,
            mk(0, 0, 0, 0, 1, 0, 32'h500, 0, 0));
        add("drop cyc",  0, 0, 0, 0, 0, 0, 0, 32'h99, ACCESS, Z);
        add("drop idle", 0, 0, 0, 0, 0, 0, 0, 0, FREE, Z);
        // RAM ERROR during a data grant
        add("t5 req",   0, 0, 0, 1, 0, 32'h300, 0, 0, FREE, Z);
        add("t5 error", 0, 0, 0, 1, 0, 32'h300, 0, 0, ERROR,
            mk(0, 0, 0, 0, 1, 0, 32'h300, 0, 0));
        add("t5 err1",  0, 0, 0, 1, 0, 32'h300, 0, 0, FREE, mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
        add("t5 err2",  0, 0, 0, 1, 0, 32'h300, 0, 32'h1, ACCESS,
            mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
        add("t5 rst",   1, 0, 0, 1, 0, 32'h300, 0, 0, FREE, mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
        add("t5 clear", 0, 0, 0, 0, 0, 0, 0, 0, FREE, Z);
        // Reset during an instruction grant, then a clean refetch
        add("t6 req",   0, 1, 32'h40, 0, 0, 0, 0, 0, FREE, Z);
        add("t6 busy",  0, 1, 32'h40, 0, 0, 0, 0, 0, BUSY, mk(0, 0, 0, 0, 1, 0, 32'h40, 0, 0));
        add("t6 rst",   1, 1, 32'h40, 0, 0, 0, 0, 0, BUSY, mk(0, 0, 0, 0, 1, 0, 32'h40, 0, 0));
        add("t6 after", 0, 1, 32'h40, 0, 0, 0, 0, 0, BUSY, Z);
        add("t6 hit",   0, 1, 32'h40, 0, 0, 0, 0, 32'h77, ACCESS,
            mk(1, 32'h77, 0, 0, 1, 0, 32'h40, 0, 0));
        add("t6 idle",  0, 0, 0, 0, 0, 0, 0, 0, FREE, Z);

        drive(1, 0, 0, 0, 0, 0, 0, 0, FREE);
        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            cycle(vecs[i].rst, vecs[i].iren, vecs[i].iaddr, vecs[i].dren, vecs[i].dwen,
                  vecs[i].daddr, vecs[i].dstore, vecs[i].ramload, vecs[i].rs);
            check(vecs[i].name, sample(), vecs[i].exp);
        end

        // Timeout: fetch with RAM stuck BUSY
        cycle(0, 1, 32'h80, 0, 0, 0, 0, 0, BUSY);
        check("t4 req", sample(), Z);
        ren_cycles = 0;
        saw_err    = 1'b0;
        saw_ihit   = 1'b0;
        for (int c = 0; c < 40 && !saw_err; c++) begin
            cycle(0, 1, 32'h80, 0, 0, 0, 0, 0, BUSY);
            if (bus.ihit) saw_ihit = 1'b1;
            if (bus.merr) saw_err = 1'b1;
            else if (bus.ramREN) ren_cycles++;
        end
        check_int("t4 granted cycles", ren_cycles, 15);
        check_int("t4 merr set", int'(saw_err), 1);
        check("t4 err state", sample(), mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
        for (int c = 0; c < 3; c++) begin
            cycle(0, 1, 32'h80, 0, 0, 0, 0, 32'h55, ACCESS);
            if (bus.ihit) saw_ihit = 1'b1;
            check($sformatf("t4 sticky%0d", c), sample(), mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
        end
        check_int("t4 no ihit", int'(saw_ihit), 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, FREE);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, FREE);
        check("t4 after rst", sample(), Z);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
